// File: rtl/sound_sm.sv
// -----------------------------------------------------------------------------
// sound_sm -- PS/2 set-2 scan-code to tone half-period decoder.
//
// Tracks make / break sequences from the PS/2 receiver and drives M, the
// half-period count loaded by the square-wave tone generator. M is nonzero
// while a mapped key is held and 0 for silence. The note table assumes a
// 25 MHz Clock: M = round(12_500_000 / f_note).
//
// Ports:
//   Clock    in   1  system clock, rising edge
//   Reset    in   1  synchronous, active-high reset
//   Keycode  in   8  scan-code byte, valid while Enable = 1
//   Enable   in   1  one-cycle strobe: consume Keycode this cycle
//   M        out 16  registered half-period count, 0 = silent
// -----------------------------------------------------------------------------
module sound_sm (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [7:0]  Keycode,
    input  logic        Enable,
    output logic [15:0] M
);

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        BRK  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  held_q,  held_d;
    logic [15:0] m_q,     m_d;

    logic [15:0] code_m_s;
    logic        mapped_s;
    logic        is_break_s;
    logic        is_ext_s;

    // Note table lookup; 0 marks an unmapped code (no table entry is 0).
    function automatic logic [15:0] note_m(input logic [7:0] code);
        logic [15:0] m;
        case (code)
            8'h15:   m = 16'd47778;  // Q  C4
            8'h1E:   m = 16'd45097;  // 2  C#4
            8'h1D:   m = 16'd42566;  // W  D4
            8'h26:   m = 16'd40177;  // 3  D#4
            8'h24:   m = 16'd37922;  // E  E4
            8'h2D:   m = 16'd35793;  // R  F4
            8'h2E:   m = 16'd33784;  // 5  F#4
            8'h2C:   m = 16'd31888;  // T  G4
            8'h36:   m = 16'd30098;  // 6  G#4
            8'h35:   m = 16'd28409;  // Y  A4
            8'h3D:   m = 16'd26815;  // 7  A#4
            8'h3C:   m = 16'd25310;  // U  B4
            8'h43:   m = 16'd23889;  // I  C5
            default: m = 16'd0;
        endcase
        return m;
    endfunction

    // Decode the incoming byte.
    always_comb begin
        code_m_s   = note_m(Keycode);
        mapped_s   = (code_m_s != 16'd0);
        is_break_s = (Keycode == CODE_BREAK);
        is_ext_s   = (Keycode == CODE_EXT);
    end

    // Next-state logic: only a cycle with Enable high can change anything.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        m_d     = m_q;
        if (Enable) begin
            case (state_q)
                IDLE: begin
                    if (mapped_s) begin
                        m_d     = code_m_s;
                        held_d  = Keycode;
                        state_d = PLAY;
                    end else if (is_break_s) begin
                        state_d = BRK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                PLAY: begin
                    if (is_break_s) begin
                        state_d = BRK;
                    end else if (mapped_s && (Keycode != held_q)) begin
                        // Last key pressed wins; a repeat of the held key is a no-op.
                        m_d    = code_m_s;
                        held_d = Keycode;
                    end else begin
                        state_d = PLAY;
                    end
                end
                BRK: begin
                    if (is_break_s || is_ext_s) begin
                        // Tolerates F0 F0 and the extended break E0 F0 xx.
                        state_d = BRK;
                    end else if ((Keycode == held_q) && (held_q != 8'd0)) begin
                        m_d     = 16'd0;
                        held_d  = 8'd0;
                        state_d = IDLE;
                    end else if (held_q != 8'd0) begin
                        // Released some other key: the held note keeps sounding.
                        state_d = PLAY;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    m_d     = 16'd0;
                    held_d  = 8'd0;
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, held code and output register; reset wins over Enable.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            held_q  <= 8'd0;
            m_q     <= 16'd0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            m_q     <= m_d;
        end
    end

    assign M = m_q;

endmodule

// File: tb/tb_sound_sm.sv
// -----------------------------------------------------------------------------
// tb_sound_sm -- self-checking bench for sound_sm.
// Expected M values are pushed to a queue as each stimulus step is driven and
// popped and compared once the DUT output is due (#1 after the rising edge).
// -----------------------------------------------------------------------------
module tb_sound_sm;

    logic        Clock;
    logic        Reset;
    logic [7:0]  Keycode;
    logic        Enable;
    logic [15:0] M;

    int vectors;
    int miscompares;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    sound_sm dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Keycode (Keycode),
        .Enable  (Enable),
        .M       (M)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Compare M with the oldest expected value in the scoreboard.
    task automatic check_out();
        logic [15:0] e;
        string       t;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: M=%0d expected <queued value>", M);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (M === e) else begin
                miscompares++;
                $error("FAIL %s: M=%0d expected %0d", t, M, e);
            end
        end
    endtask

    task automatic expect_m(input logic [15:0] e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    // One Enable strobe with code, then check M one cycle later.
    task automatic strobe(input logic [7:0] code, input logic [15:0] e, input string t);
        @(negedge Clock);
        Keycode = code;
        Enable  = 1'b1;
        expect_m(e, t);
        @(posedge Clock);
        #1;
        Enable  = 1'b0;
        Keycode = 8'h00;
        check_out();
    endtask

    // Idle for n cycles, then confirm M did not move.
    task automatic gap(input int n, input logic [15:0] e, input string t);
        expect_m(e, t);
        repeat (n) @(posedge Clock);
        #1;
        check_out();
    endtask

    task automatic do_reset(input int n);
        @(negedge Clock);
        Reset = 1'b1;
        repeat (n) @(posedge Clock);
        #1;
        expect_m(16'd0, "reset");
        check_out();
        Reset = 1'b0;
    endtask

    logic [7:0]  codes [13];
    logic [15:0] notes [13];

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset   = 1'b0;
        Enable  = 1'b0;
        Keycode = 8'h00;
        codes = '{8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h2D, 8'h2E,
                  8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C, 8'h43};
        notes = '{16'd47778, 16'd45097, 16'd42566, 16'd40177, 16'd37922,
                  16'd35793, 16'd33784, 16'd31888, 16'd30098, 16'd28409,
                  16'd26815, 16'd25310, 16'd23889};

        // Reset 2 cycles, then first note.
        do_reset(2);
        gap(3, 16'd0, "post_reset_silent");
        strobe(8'h15, 16'd47778, "first_note_c4");

        // Make / break / release, unmapped in IDLE, then repeat.
        gap(25, 16'd47778, "c4_held");
        strobe(8'hF0, 16'd47778, "break_prefix_keeps_m");
        gap(25, 16'd47778, "brk_wait");
        strobe(8'h15, 16'd0, "release_c4");
        gap(25, 16'd0, "idle_silent");
        strobe(8'h00, 16'd0, "unmapped_in_idle");
        strobe(8'h15, 16'd47778, "repeat_make");
        strobe(8'hF0, 16'd47778, "repeat_break");
        strobe(8'h15, 16'd0, "repeat_release");

        // Last key wins; releasing a non-sounding key keeps the note.
        strobe(8'h15, 16'd47778, "lkw_c4");
        strobe(8'h35, 16'd28409, "lkw_a4");
        strobe(8'hF0, 16'd28409, "lkw_break");
        strobe(8'h15, 16'd28409, "release_other_key");
        strobe(8'h24, 16'd37922, "back_in_play_e4");
        strobe(8'h35, 16'd28409, "back_to_a4");
        strobe(8'hF0, 16'd28409, "a4_break");
        strobe(8'h35, 16'd0, "a4_release");

        // Typematic repeat and unmapped code in PLAY.
        for (int i = 0; i < 5; i++) strobe(8'h1D, 16'd42566, "typematic_d4");
        strobe(8'h1C, 16'd42566, "unmapped_in_play");
        strobe(8'hE0, 16'd42566, "ext_in_play");

        // Extended break E0 F0 xx and repeated F0 while in BRK.
        strobe(8'hF0, 16'd42566, "f0_first");
        strobe(8'hF0, 16'd42566, "f0_again");
        strobe(8'hE0, 16'd42566, "e0_in_brk");
        strobe(8'h1D, 16'd0, "ext_release_d4");

        // F0 from IDLE then a mapped code: nothing held, back to IDLE silent.
        strobe(8'hF0, 16'd0, "idle_break");
        strobe(8'h2C, 16'd0, "idle_break_code");
        strobe(8'h2C, 16'd31888, "idle_after_brk_g4");
        strobe(8'hF0, 16'd31888, "g4_break");
        strobe(8'h2C, 16'd0, "g4_release");

        // Whole note table, last key wins each step.
        for (int i = 0; i < 13; i++) strobe(codes[i], notes[i], $sformatf("table_%02h", codes[i]));
        strobe(8'hF0, 16'd23889, "table_break");
        strobe(8'h43, 16'd0, "table_release");

        // Reset while in BRK.
        strobe(8'h43, 16'd23889, "brk_rst_c5");
        strobe(8'hF0, 16'd23889, "brk_rst_break");
        do_reset(1);
        strobe(8'h43, 16'd23889, "after_reset_in_brk");

        // Reset and Enable in the same cycle: reset wins.
        @(negedge Clock);
        Reset   = 1'b1;
        Enable  = 1'b1;
        Keycode = 8'h24;
        expect_m(16'd0, "reset_beats_enable");
        @(posedge Clock);
        #1;
        check_out();

        // Enable held 3 cycles with the same byte: idempotent.
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_m(16'd37922, "enable_held_e4");
            @(posedge Clock);
            #1;
            check_out();
        end
        Enable  = 1'b0;
        Keycode = 8'h00;

        // Enable held 2 cycles on F0, then release.
        @(negedge Clock);
        Keycode = 8'hF0;
        Enable  = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        expect_m(16'd37922, "held_f0");
        check_out();
        Enable = 1'b0;
        strobe(8'h24, 16'd0, "held_f0_release");
        gap(5, 16'd0, "final_silent");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
